// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, add-3 constants and a constant-sizing helper.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// One BCD nibble of the double-dabble pre-shift correction:
// nibbles of 5 or more get +3 so the following shift carries correctly.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] in_nib,
    output logic [3:0] out_nib
);

    assign out_nib = (in_nib >= BCD_ADJ_THRESH) ? (in_nib + BCD_ADJ_ADD) : in_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one operand bit per SHIFT cycle,
// result and leading-zero flags registered on the last shift.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [SW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] lz_q, lz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [SW-1:0]     scr_adj;
    logic [SW-1:0]     scr_shift;
    logic [WIDTH-1:0]  op_shift;
    logic [DIGITS-1:0] lz_calc;
    logic              lz_run;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .in_nib  (scr_q[4*g +: 4]),
            .out_nib (scr_adj[4*g +: 4])
        );
    end

    // Operand MSB enters the scratch LSB as the pair shifts left.
    assign scr_shift = (scr_adj << 1) | SW'(op_q[WIDTH-1]);
    assign op_shift  = op_q << 1;

    // Digit 0 is never blanked so a zero result still shows "0".
    always_comb begin
        lz_run  = 1'b1;
        lz_calc = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (scr_shift[4*i +: 4] == 4'd0);
            lz_calc[i] = lz_run;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        lz_d    = lz_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    op_d    = bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                scr_d = scr_shift;
                op_d  = op_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = scr_shift;
                    lz_d    = lz_calc;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            lz_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            lz_q    <= lz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign lz_mask = lz_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter. Uses the iterative shift-add-3 method (double dabble).
- Sits directly downstream of the frequency decoder. It takes that decoder's 10-bit frequency value (0, 30..200) and produces packed BCD digits plus leading-zero flags.
- Its outputs feed the 7-segment display multiplexer.
- Starts one conversion per start request. Returns the result after a fixed latency with a busy/done handshake.

Parameters:
- WIDTH, 10, bit width of the binary input.
- DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  WIDTH  binary value to convert; latched on the accepted start.
- busy  output  1  high while the conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse; bcd_out and lz_mask are updated and valid.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0], the most significant digit in the top nibble.
- lz_mask  output  DIGITS  bit i=1 means digit i is a leading zero (display blanks it); bit 0 is always 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (while rst_n=0):
  - state=IDLE, busy=0, done=0.
  - bcd_out=0, lz_mask=0.
  - Internal operand, scratch and counter all 0.
- Reset mid-operation: aborts the conversion immediately. No done pulse follows. bcd_out returns to 0.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT). done = (state==DONE).
- IDLE:
  - If start=1 at edge k: latch bin_in into the operand, clear the BCD scratch, set cnt=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on each edge:
  - First, every scratch nibble >=5 gets +3 (4-bit add, no carry out of the nibble).
  - Then the {scratch, operand} concatenation shifts left by 1. The operand MSB enters the scratch LSB.
  - cnt increments.
  - When cnt==WIDTH-1 at the edge: load the shifted result into bcd_out, load the computed lz_mask, go to DONE.
- DONE: lasts one cycle, with done=1 and busy=0. Then unconditionally go to IDLE.
- Latency:
  - Edges k+1..k+WIDTH are the WIDTH SHIFT edges.
  - done is high in the cycle following edge k+WIDTH (10 edges after acceptance for WIDTH=10).
  - Throughput is one conversion per WIDTH+2 cycles.
- start handling:
  - start during SHIFT or DONE is ignored; it is not queued.
  - start held high continuously restarts a conversion on each return to IDLE.
- bin_in changes after acceptance have no effect on the current result.
- bcd_out and lz_mask hold their last values between conversions. They change only on the final SHIFT edge or on reset.
- lz_mask rule: scan from the most significant digit downward. Bit i=1 if digit i and all higher digits are 0, for i>=1. Bit 0 is forced to 0, so a value of 0 shows a single "0".
- Width rule: scratch is 4*DIGITS bits. No overflow can occur when the parameter constraint holds.

Decomposition:
- Shared package (display package):
  - state encoding enum {IDLE, SHIFT, DONE}.
  - constants BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3.
  - function clog2 for sizing the counter, with cnt width = clog2(WIDTH).
- Sub-module: bcd_digit_adj. Combinational 4-bit nibble: out = (in>=5) ? in+3 : in. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset then start with bin_in=200:
  - busy is high for 10 cycles.
  - done pulses once, with bcd_out=16'h0200 and lz_mask=4'b1000.
- start with bin_in=0 → bcd_out=16'h0000, lz_mask=4'b1110.
- start with bin_in=1023 → bcd_out=16'h1023, lz_mask=4'b0000.
- Sweep all decoder outputs {30,50,75,100,125,150,175,200}:
  - each result equals its decimal value, e.g. 75 → 16'h0075 with lz_mask=4'b1100.
  - done latency is exactly 10 edges after acceptance every time.
- Protocol checks:
  - start pulsed during SHIFT, and during the DONE cycle, is ignored.
  - bin_in changed from 50 to 150 mid-conversion still yields 16'h0050.
  - start one cycle after DONE is accepted.
- Assert rst_n=0 on the 5th SHIFT edge of a conversion of 175:
  - all outputs go to 0 immediately and asynchronously.
  - no done pulse follows.
  - the next conversion of 175 yields 16'h0175.
